// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Direction/mode encodings and the clamp used for load and step limits.
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic logic [31:0] clamp_to_max(
        input logic [31:0] value,
        input logic [31:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count datapath with crossing detection.
// Sums are one bit wider than the count so nothing truncates mid-way.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             updown,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] MODV = MAXV + (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] s_x;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] wrap_up;
    logic [WIDTH:0] wrap_dn;
    logic [WIDTH:0] diff;

    assign cnt_x   = {1'b0, count};
    assign s_x     = {1'b0, s};
    assign sum     = cnt_x + s_x;
    assign wrap_up = sum - MODV;
    assign diff    = cnt_x - s_x;
    assign wrap_dn = cnt_x + MODV - s_x;

    // Pick next value and flag a crossing of either bound.
    always_comb begin
        nxt = count;
        ovf = 1'b0;
        unf = 1'b0;
        if (updown == DIR_UP) begin
            if (sum > MAXV) begin
                ovf = 1'b1;
                nxt = (sat_mode == MODE_SAT) ? MAXV[WIDTH-1:0]
                                             : wrap_up[WIDTH-1:0];
            end else begin
                nxt = sum[WIDTH-1:0];
            end
        end else begin
            if (cnt_x < s_x) begin
                unf = 1'b1;
                nxt = (sat_mode == MODE_SAT) ? '0
                                             : wrap_dn[WIDTH-1:0];
            end else begin
                nxt = diff[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable modulus, step and wrap/saturate.
// Holds the state registers, clr > load > en priority and load clamping.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1,
    parameter int          STEP_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              en,
    input  logic              updown,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              tc_up,
    output logic              tc_down,
    output logic              ovf,
    output logic              unf,
    output logic              load_err
);

    localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d_clamped;
    logic             load_over;
    logic [WIDTH-1:0] nxt;
    logic             c_ovf;
    logic             c_unf;

    assign s         = WIDTH'(clamp_to_max(32'(step), 32'(MAX_COUNT)));
    assign d_clamped = WIDTH'(clamp_to_max(32'(d_in), 32'(MAX_COUNT)));
    assign load_over = 32'(d_in) > 32'(MAX_COUNT);

    assign tc_up   = (count == MAXW);
    assign tc_down = (count == '0);

    counter_next_calc #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_calc (
        .count    (count),
        .s        (s),
        .updown   (updown),
        .sat_mode (sat_mode),
        .nxt      (nxt),
        .ovf      (c_ovf),
        .unf      (c_unf)
    );

    // Count register and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            ovf      <= 1'b0;
            unf      <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count    <= d_clamped;
                load_err <= load_over;
            end else if (en) begin
                count <= nxt;
                ovf   <= c_ovf;
                unf   <= c_unf;
            end
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: directed vectors push expectations, a monitor checks.
// DUT A is a decade counter (W=4, max 9); DUT B uses default W=8.
module tb_param_updown_counter;

    typedef struct {
        int         sel;
        string      tag;
        logic [7:0] cnt;
        logic       tcu;
        logic       tcd;
        logic       ovf;
        logic       unf;
        logic       lerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_clr = 0, a_load = 0, a_en = 0, a_ud = 0, a_sat = 0;
    logic [3:0] a_d = '0, a_step = '0;
    logic [3:0] a_count;
    logic       a_tcu, a_tcd, a_ovf, a_unf, a_lerr;

    logic       b_clr = 0, b_load = 0, b_en = 0, b_ud = 0, b_sat = 0;
    logic [7:0] b_d = '0;
    logic [3:0] b_step = '0;
    logic [7:0] b_count;
    logic       b_tcu, b_tcd, b_ovf, b_unf, b_lerr;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_updown_counter #(
        .WIDTH(4), .MAX_COUNT(9), .STEP_W(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load),
        .d_in(a_d), .en(a_en), .updown(a_ud), .sat_mode(a_sat),
        .step(a_step), .count(a_count), .tc_up(a_tcu),
        .tc_down(a_tcd), .ovf(a_ovf), .unf(a_unf), .load_err(a_lerr)
    );

    param_updown_counter dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load),
        .d_in(b_d), .en(b_en), .updown(b_ud), .sat_mode(b_sat),
        .step(b_step), .count(b_count), .tc_up(b_tcu),
        .tc_down(b_tcd), .ovf(b_ovf), .unf(b_unf), .load_err(b_lerr)
    );

    task automatic compare(input string tag, input logic [12:0] act,
                           input logic [12:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d tcu=%b tcd=%b ovf=%b unf=%b lerr=%b, need cnt=%0d tcu=%b tcd=%b ovf=%b unf=%b lerr=%b",
                     tag, act[12:5], act[4], act[3], act[2], act[1], act[0],
                     req[12:5], req[4], req[3], req[2], req[1], req[0]);
        end
    endtask

    // Monitor: after each rising edge, check the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        logic [12:0] act;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.sel == 0)
                act = {4'b0, a_count, a_tcu, a_tcd, a_ovf, a_unf, a_lerr};
            else
                act = {b_count, b_tcu, b_tcd, b_ovf, b_unf, b_lerr};
            compare(e.tag, act,
                    {e.cnt, e.tcu, e.tcd, e.ovf, e.unf, e.lerr});
        end
    end

    // Drive one vector on the chosen DUT and queue its expected result.
    task automatic vec(input int sel, input string tag,
                       input logic clr, input logic load,
                       input logic [7:0] d, input logic en,
                       input logic ud, input logic sat,
                       input logic [3:0] stp,
                       input logic [7:0] ecnt, input logic eovf,
                       input logic eunf, input logic elerr);
        exp_t e;
        @(negedge clk);
        a_clr = 0; a_load = 0; a_en = 0;
        b_clr = 0; b_load = 0; b_en = 0;
        if (sel == 0) begin
            a_clr = clr; a_load = load; a_d = d[3:0]; a_en = en;
            a_ud = ud; a_sat = sat; a_step = stp;
        end else begin
            b_clr = clr; b_load = load; b_d = d; b_en = en;
            b_ud = ud; b_sat = sat; b_step = stp;
        end
        e.sel  = sel;
        e.tag  = tag;
        e.cnt  = ecnt;
        e.tcu  = (sel == 0) ? (ecnt == 8'd9) : (ecnt == 8'd255);
        e.tcd  = (ecnt == 8'd0);
        e.ovf  = eovf;
        e.unf  = eunf;
        e.lerr = elerr;
        q.push_back(e);
    endtask

    initial begin
        #3;
        compare("reset_a", {4'b0, a_count, a_tcu, a_tcd, a_ovf, a_unf, a_lerr},
                {8'd0, 1'b0, 1'b1, 3'b000});
        @(negedge clk);
        rst_n = 1'b1;

        //      sel tag          clr ld d   en ud sat stp  cnt ovf unf lerr
        vec(0, "ld7",           0, 1, 7,  0, 1, 0, 1,   7, 0, 0, 0);
        vec(0, "up_to8",        0, 0, 0,  1, 1, 0, 1,   8, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compare("async_rst", {4'b0, a_count, a_tcu, a_tcd, a_ovf, a_unf, a_lerr},
                {8'd0, 1'b0, 1'b1, 3'b000});
        @(negedge clk);
        rst_n = 1'b1;

        vec(0, "ld5",           0, 1, 5,  0, 1, 0, 1,   5, 0, 0, 0);
        vec(0, "clr_over_ld",   1, 1, 6,  1, 1, 0, 1,   0, 0, 0, 0);
        vec(0, "ld8",           0, 1, 8,  0, 1, 0, 1,   8, 0, 0, 0);
        vec(0, "up_9_tc",       0, 0, 0,  1, 1, 0, 1,   9, 0, 0, 0);
        vec(0, "wrap_0_ovf",    0, 0, 0,  1, 1, 0, 1,   0, 1, 0, 0);
        vec(0, "idle_ovf_low",  0, 0, 0,  0, 1, 0, 1,   0, 0, 0, 0);
        vec(0, "ld1",           0, 1, 1,  0, 0, 0, 3,   1, 0, 0, 0);
        vec(0, "dn3_wrap_8",    0, 0, 0,  1, 0, 0, 3,   8, 0, 1, 0);
        vec(0, "dn3_5",         0, 0, 0,  1, 0, 0, 3,   5, 0, 0, 0);
        vec(0, "ld7s",          0, 1, 7,  0, 1, 1, 4,   7, 0, 0, 0);
        vec(0, "sat_up_9",      0, 0, 0,  1, 1, 1, 4,   9, 1, 0, 0);
        vec(0, "sat_hold_9",    0, 0, 0,  1, 1, 1, 4,   9, 1, 0, 0);
        vec(0, "sat_en0",       0, 0, 0,  0, 1, 1, 4,   9, 0, 0, 0);
        vec(0, "ld13_clamp",    0, 1, 13, 1, 1, 0, 1,   9, 0, 0, 1);
        vec(0, "ld4",           0, 1, 4,  1, 1, 0, 1,   4, 0, 0, 0);
        vec(0, "step0_hold",    0, 0, 0,  1, 1, 0, 0,   4, 0, 0, 0);
        vec(0, "step15_cl_up",  0, 0, 0,  1, 1, 0, 15,  3, 1, 0, 0);
        vec(0, "sat_dn_0",      0, 0, 0,  1, 0, 1, 4,   0, 0, 1, 0);
        vec(0, "sat_dn_hold",   0, 0, 0,  1, 0, 1, 4,   0, 0, 1, 0);
        vec(1, "b_ld250",       0, 1, 250,0, 1, 0, 15, 250, 0, 0, 0);
        vec(1, "b_up15_wrap",   0, 0, 0,  1, 1, 0, 15,  9, 1, 0, 0);
        vec(1, "b_dn15_wrap",   0, 0, 0,  1, 0, 0, 15, 250, 0, 1, 0);
        vec(1, "b_ld255",       0, 1, 255,0, 1, 0, 1, 255, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous up/down counter with programmable width, modulus and step size.
- Supports synchronous clear, parallel load, count enable, and a wrap or saturate mode selected at run time.
- Reports terminal count, and emits one-cycle overflow/underflow pulses.
- General-purpose timing/event counter used by timer, divider and sequencer blocks; next generation of the fixed 4-bit up/down counter.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MAX_COUNT, 2**WIDTH-1, highest legal count value; count range is 0..MAX_COUNT, modulus MAX_COUNT+1 (must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1).
- STEP_W, 4, width of step input (STEP_W ≤ WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear, active high.
- load  in  1  synchronous load of d_in, active high.
- d_in  in  WIDTH  load value.
- en  in  1  count enable.
- updown  in  1  1 = up, 0 = down.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MAX_COUNT+1.
- step  in  STEP_W  increment/decrement magnitude per enabled cycle.
- count  out  WIDTH  current count (registered).
- tc_up  out  1  count == MAX_COUNT (combinational from count).
- tc_down  out  1  count == 0 (combinational from count).
- ovf  out  1  registered one-cycle pulse: up-step crossed MAX_COUNT.
- unf  out  1  registered one-cycle pulse: down-step crossed 0.
- load_err  out  1  registered one-cycle pulse: d_in > MAX_COUNT was loaded (clamped).

Behaviour:
- Reset: rst_n low → count=0, ovf=unf=load_err=0 immediately (async). Deassertion takes effect on next clk edge; no count until then.
- Priority per edge: clr > load > en. ovf, unf and load_err default to 0 every cycle unless set below.
- clr: count←0. Flags 0.
- load: count←d_in if d_in ≤ MAX_COUNT. Otherwise count←MAX_COUNT and load_err←1. en ignored that cycle.
- Effective step: s = min(step, MAX_COUNT). s=0 → count holds, no flags.
- en=0: count holds.
- Up, no crossing (count+s ≤ MAX_COUNT): count←count+s.
- Up, crossing: ovf←1. Wrap mode: count←count+s-(MAX_COUNT+1). Sat mode: count←MAX_COUNT.
- Down, no crossing (count ≥ s): count←count-s.
- Down, crossing: unf←1. Wrap mode: count←count+(MAX_COUNT+1)-s. Sat mode: count←0.
- Saturate already at bound (e.g. count=MAX_COUNT, up, s>0): count holds, ovf←1 each enabled cycle (sticky-pressure indication).
- Arithmetic: internal sums are WIDTH+1 bits; no intermediate truncation. One subtraction/addition of modulus suffices since s ≤ MAX_COUNT.
- updown, sat_mode and step are sampled only on enabled edges. Changing them mid-run takes effect on the next edge, with no pipeline.
- Latency: count reflects an op one edge after sampling. tc_up/tc_down follow count combinationally. ovf/unf are aligned with the count update that caused them.
- Reset asserted mid-operation overrides everything asynchronously. Any pending flag pulse is cleared.

Decomposition:
- Shared package counter_pkg holds:
  - localparams DIR_DOWN=1'b0, DIR_UP=1'b1, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - a function clamp_to_max(value, max) reused by load and step clamping.
- One combinational sub-module, counter_next_calc, computes next count plus ovf/unf from (count, s, updown, sat_mode).
- The top module holds the registers, priority logic and load clamping.

Test Plan:
- Reset/clear: WIDTH=4, MAX_COUNT=9. Assert rst_n=0 mid-count at 7 → count=0 and all flags 0 immediately. clr=1 with load=1 → count=0.
- Decade wrap up: MAX_COUNT=9, step=1, wrap, up from 8 → 9 (tc_up=1) → 0 with ovf=1 for exactly one cycle.
- Multi-step wrap down: MAX_COUNT=9, step=3, wrap, down from 1 → 8, unf=1. Next edge 5, unf=0.
- Saturate: MAX_COUNT=9, step=4, sat, up from 7 → 9 with ovf=1. Next enabled edge count stays 9, ovf=1 again. en=0 → ovf=0.
- Load clamp and priority: d_in=13 with MAX_COUNT=9, load=1, en=1 → count=9, load_err=1 for one cycle, no ovf. d_in=4 → count=4, load_err=0.
- Step edge cases: step=0, en=1 → count holds, no flags. WIDTH=8 default, step=15, up from 250 wrap → 9 with ovf=1.
